router_fsm: RTL



---
 rtl/router_pkg.sv | 33 +++
 rtl/router_fsm.sv | 137 +++++++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: FSM state encoding, port addresses
// and the synchronizer's soft-reset timeout.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    // Debug view of the controller: current state and latched destination.
    typedef struct packed {
        state_t     state;
        logic [1:0] addr;
    } fsm_dbg_t;

    localparam logic [1:0] ADDR_0       = 2'b00;
    localparam logic [1:0] ADDR_1       = 2'b01;
    localparam logic [1:0] ADDR_2       = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    localparam int SOFT_RESET_TIMEOUT = 30;

    function automatic logic addr_valid(input logic [1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the router input side: a Moore FSM that
// latches the destination port and steers FIFO writes and the register block.
module router_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output fsm_dbg_t   dbg
);

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_q;
    logic       hdr_ok;
    logic       hdr_empty;
    logic       sel_empty;
    logic       sel_soft;

    // Header qualification looks at the live address bits; everything after
    // the header works off the latched address.
    always_comb begin
        hdr_ok = pkt_valid && addr_valid(data_in);
        case (data_in)
            ADDR_0:  hdr_empty = fifo_empty_0;
            ADDR_1:  hdr_empty = fifo_empty_1;
            ADDR_2:  hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
        case (addr_q)
            ADDR_0:  begin sel_empty = fifo_empty_0; sel_soft = soft_reset_0; end
            ADDR_1:  begin sel_empty = fifo_empty_1; sel_soft = soft_reset_1; end
            ADDR_2:  begin sel_empty = fifo_empty_2; sel_soft = soft_reset_2; end
            default: begin sel_empty = 1'b0;         sel_soft = 1'b0;         end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= ADDR_0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && hdr_ok) begin
                addr_q <= data_in;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) next_state = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        // A timeout on the selected port abandons the packet from any state.
        if (sel_soft && state != DECODE_ADDRESS) begin
            next_state = DECODE_ADDRESS;
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            FIFO_FULL_STATE: full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY:        write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
            default: ;
        endcase
        dbg.state = state;
        dbg.addr  = addr_q;
    end

endmodule
